button_press_decoder: RTL and testbench
=======================================

BUTTON_PRESS_DECODER -- requirements
Module: button_press_decoder

Interface
REQ-001 Parameter CNT_W, default 16: width of the internal cycle counter.
REQ-002 Parameter LONG_CYCLES, default 40000: consecutive high samples that make a long press; legal range 2..2^CNT_W-1.
REQ-003 Parameter GAP_CYCLES, default 10000: maximum low samples between presses for a double press; legal range 2..2^CNT_W-1.
REQ-004 clk  in  1: single clock; all state SHALL change on its rising edge.
REQ-005 n_reset  in  1: asynchronous, active-low reset.
REQ-006 db_in  in  1: debounced button level from the debounce stage; 1 = pressed; synchronous to clk.
REQ-007 enable  in  1: synchronous enable; 0 forces idle.
REQ-008 short_press  out  1: one-cycle pulse, single short press.
REQ-009 long_press  out  1: one-cycle pulse, press held LONG_CYCLES.
REQ-010 double_press  out  1: one-cycle pulse, two short presses within GAP_CYCLES.
REQ-011 busy  out  1: high whenever the FSM is not IDLE.

Function
REQ-012 The block SHALL register db_in into db_q; rise = db_in & ~db_q; fall = ~db_in & db_q.
REQ-013 The FSM SHALL have exactly these states: IDLE, PRESS1, LONG_HELD, GAP, PRESS2.
REQ-014 IDLE: on rise with enable=1, go to PRESS1 and start the counter; E denotes the cycle in which rise is sampled.
REQ-015 PRESS1: if db_in is high in cycles E..E+LONG_CYCLES-1, long_press SHALL be high in cycle E+LONG_CYCLES only, and the FSM SHALL go to LONG_HELD.
REQ-016 PRESS1: a fall sampled before that point SHALL go to GAP and restart the counter; R denotes the cycle of the fall.
REQ-017 LONG_HELD: no outputs SHALL pulse; on fall, go to IDLE; a release after a long press SHALL never yield short_press.
REQ-018 GAP: if db_in stays low in cycles R..R+GAP_CYCLES-1, short_press SHALL be high in cycle R+GAP_CYCLES only, then go to IDLE.
REQ-019 GAP: a rise sampled within R+1..R+GAP_CYCLES-1 SHALL go to PRESS2 with no pulse.
REQ-020 PRESS2: on fall sampled at cycle F, double_press SHALL be high in cycle F+1 only, then go to IDLE; hold duration in PRESS2 is ignored (no long_press).
REQ-021 The counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 enable=0 in any state SHALL force IDLE on the next edge, clear the counter, and suppress all pulses from that edge on; a press already in progress when enable rises SHALL NOT be detected (rise needed).
REQ-023 At most one of short_press, long_press and double_press SHALL be high in any cycle.
REQ-024 All outputs SHALL be driven from registers (no combinational path from db_in).
REQ-025 The block SHALL be back-to-back capable: a rise in the cycle after a pulse (FSM in IDLE) SHALL start a new detection.

Reset
REQ-026 n_reset=0 SHALL asynchronously force state IDLE, counter 0, db_q 0, and all four outputs to 0.
REQ-027 Reset asserted mid-operation (any state) SHALL discard the pending event with no pulse; after release, db_in already high SHALL produce a rise (db_q=0).
REQ-028 The first active clock edge after n_reset deasserts SHALL evaluate normally; no extra synchronisation latency is added.

Verification (LONG_CYCLES=8, GAP_CYCLES=5, CNT_W=4)
REQ-029 db_in high for 3 cycles from E=10, then low -> short_press=1 only at cycle 13+5=18; busy low from 19.
REQ-030 db_in high for 20 cycles from E=10 -> long_press=1 only at cycle 18; no pulse at release; busy low after the fall.
REQ-031 db_in high 10-12, low 13-14, high 15-17, low from 18 -> double_press=1 only at cycle 19; no short_press.
REQ-032 db_in high 10-12, low 13-17, high from 18 -> short_press at 18; cycle-18 rise ignored (FSM in GAP); no second detection until the next rise.
REQ-033 n_reset pulsed low at cycle 14 during PRESS1 with db_in still high -> outputs 0 immediately; after release a new rise is sampled and long_press fires 8 cycles later.
REQ-034 enable=0 at cycle 12 during PRESS1 -> no pulse for that press; busy low by cycle 13; a later rise with enable=1 is decoded normally.

Source files
------------

// File: rtl/button_press_decoder.sv
// Button press decoder: classifies debounced presses into
// short, long and double events with one-cycle pulses.
module button_press_decoder #(
  parameter int CNT_W       = 16,
  parameter int LONG_CYCLES = 40000,
  parameter int GAP_CYCLES  = 10000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic db_in,
  input  logic enable,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESS1    = 3'd1;
  localparam logic [2:0] LONG_HELD = 3'd2;
  localparam logic [2:0] GAP       = 3'd3;
  localparam logic [2:0] PRESS2    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_DONE  = CNT_W'(GAP_CYCLES);

  logic [2:0]       state;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             db_q;
  logic             rise;
  logic             fall;
  logic             short_d;
  logic             long_d;
  logic             double_d;

  assign rise    = db_in & ~db_q;
  assign fall    = ~db_in & db_q;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign busy    = (state != IDLE);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_d = PRESS1;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS1: begin
          if (fall) begin
            state_d = GAP;
            cnt_d   = CNT_ONE;
          end else if (cnt >= LONG_LAST) begin
            state_d = LONG_HELD;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        GAP: begin
          // the pulse cycle itself still belongs to GAP
          if (cnt == GAP_DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (rise) begin
            state_d = PRESS2;
            cnt_d   = '0;
          end else if (cnt == GAP_LAST) begin
            short_d = 1'b1;
            cnt_d   = cnt_inc;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESS2: begin
          if (fall) begin
            state_d  = IDLE;
            cnt_d    = '0;
            double_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      db_q         <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      db_q         <= db_in;
      short_press  <= short_d;
      long_press   <= long_d;
      double_press <= double_d;
    end
  end

endmodule

// File: tb/tb_button_press_decoder.sv
// Scoreboard bench for button_press_decoder with small
// LONG/GAP parameters and directed press waveforms.
module tb_button_press_decoder;

  logic clk = 1'b0;
  logic n_reset;
  logic db_in;
  logic enable;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t q[$];

  button_press_decoder #(
    .CNT_W(4),
    .LONG_CYCLES(8),
    .GAP_CYCLES(5)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .db_in(db_in),
    .enable(enable),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // kind code: 1 short, 2 long, 4 double
  always @(negedge clk) begin
    int kind;
    exp_t e;
    kind = {29'd0, double_press, long_press, short_press};
    if (n_reset && kind != 0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse kind=%0d cyc=%0d required none",
                 kind, cyc + 1);
      end else begin
        e = q.pop_front();
        if (e.kind != kind || e.cyc != cyc + 1) begin
          errors++;
          $display("FAIL pulse got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                   kind, cyc + 1, e.kind, e.cyc);
        end
      end
    end
  end

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] r;
    r = '0;
    for (int i = a; i <= b; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk_busy(input string name, input logic want);
    checks++;
    if (busy !== want) begin
      errors++;
      $display("FAIL %s busy=%b required %b", name, busy, want);
    end
  endtask

  // Called on a negedge; relative cycle k drives edge base+k.
  task automatic run_seq(
    input string       name,
    input logic [63:0] hi,
    input logic [63:0] en_lo,
    input logic [63:0] rst,
    input int          len,
    input int          k1,
    input int          c1,
    input int          k2,
    input int          c2,
    input int          bhi,
    input int          blo
  );
    int base;
    base = cyc + 1;
    if (k1 != 0) q.push_back('{k1, base + c1});
    if (k2 != 0) q.push_back('{k2, base + c2});
    for (int k = 0; k < len; k++) begin
      db_in   = hi[k];
      enable  = ~en_lo[k];
      n_reset = ~rst[k];
      #1;
      if (rst[k]) begin
        checks++;
        if ({busy, short_press, long_press, double_press} !== 4'b0) begin
          errors++;
          $display("FAIL %s_reset outs=%b required 0000", name,
                   {busy, short_press, long_press, double_press});
        end
      end
      if (k == bhi) chk_busy({name, "_busy_hi"}, 1'b1);
      if (k == blo) chk_busy({name, "_busy_lo"}, 1'b0);
      @(negedge clk);
    end
    db_in   = 1'b0;
    enable  = 1'b1;
    n_reset = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing pending=%0d required 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    n_reset = 1'b0;
    db_in   = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, short_press, long_press, double_press} !== 4'b0) begin
      errors++;
      $display("FAIL reset_state outs=%b required 0000",
               {busy, short_press, long_press, double_press});
    end
    n_reset = 1'b1;
    @(negedge clk);

    run_seq("short", rng(10, 12), '0, '0, 25, 1, 18, 0, 0, 18, 19);
    run_seq("long", rng(10, 29), '0, '0, 36, 2, 18, 0, 0, 30, 31);
    run_seq("double", rng(10, 12) | rng(15, 17), '0, '0, 25,
            4, 19, 0, 0, 18, 19);
    run_seq("gap_edge", rng(10, 12) | rng(18, 22), '0, '0, 35,
            1, 18, 0, 0, 18, 19);
    run_seq("reset", rng(10, 25), '0, rng(14, 14), 35,
            2, 23, 0, 0, 12, -1);
    run_seq("enable", rng(10, 14) | rng(20, 22), rng(12, 12), '0, 35,
            1, 28, 0, 0, 11, 13);
    run_seq("b2b", rng(10, 12) | rng(19, 30), '0, '0, 40,
            1, 18, 2, 27, -1, -1);
    run_seq("late_rise", rng(10, 12) | rng(17, 18), '0, '0, 30,
            4, 20, 0, 0, -1, -1);
    run_seq("almost_long", rng(10, 16), '0, '0, 30,
            1, 22, 0, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
